// File: rtl/conv2d_engine.sv
// conv2d_engine: K x K signed-kernel 2-D convolution of an N x N unsigned image read from a source BRAM.
// Define CONV2D_CLAMP_EN to saturate the normalised result to [0, 2^DW-1]; otherwise the low DW bits are kept.
module conv2d_engine #(
  parameter int N      = 20,
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int CW     = 4,
  parameter int RD_LAT = 1,
  parameter int SAW    = 15,
  parameter int DAW    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 coef_we,
  input  logic [5:0]           coef_idx,
  input  logic signed [CW-1:0] coef_data,
  input  logic [3:0]           norm_shift,
  output logic                 src_en,
  output logic [SAW-1:0]       src_addr,
  input  logic [DW-1:0]        src_data,
  output logic                 dst_we,
  output logic [DAW-1:0]       dst_addr,
  output logic [DW-1:0]        dst_data
);

  localparam int KK = K * K;
  localparam int NO = N - K + 1;
  localparam int TW = (KK > 1) ? $clog2(KK) : 1;
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam int OW = (NO > 1) ? $clog2(NO) : 1;
  localparam int AW = DW + 1 + CW + $clog2(KK);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << DW) - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  logic signed [CW-1:0]  r_coef [KK];
  logic [3:0]            r_shift;
  logic [OW-1:0]         r_orow, r_ocol;
  logic [RW-1:0]         r_kr, r_kc;
  logic [TW-1:0]         r_tap;
  logic [1:0]            r_dcnt;
  logic signed [AW-1:0]  r_acc;
  logic                  r_pv [RD_LAT];
  logic [TW-1:0]         r_pt [RD_LAT];

  logic signed [AW-1:0]  w_cext, w_dext, w_acc_next, w_shifted;
  logic [DW-1:0]         w_norm;
  logic [RW-1:0]         w_kr_n, w_kc_n;
  logic [OW-1:0]         w_nrow, w_ncol;
  logic                  w_last_tap, w_last_pix;

  function automatic logic [SAW-1:0] f_src(input logic [OW-1:0] orow, input logic [OW-1:0] ocol,
                                           input logic [RW-1:0] kr, input logic [RW-1:0] kc);
    return SAW'((32'(orow) + 32'(kr)) * N + 32'(ocol) + 32'(kc));
  endfunction

  // Tap index travels alongside the read so returning data meets its own coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pt[i] <= '0;
      end
    end else begin
      r_pv[0] <= src_en;
      r_pt[0] <= r_tap;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
    end
  end

  always_comb begin
    w_cext     = AW'(r_coef[r_pt[RD_LAT-1]]);
    w_dext     = AW'({1'b0, src_data});
    w_acc_next = r_pv[RD_LAT-1] ? (r_acc + w_cext * w_dext) : r_acc;
    w_shifted  = w_acc_next >>> r_shift;
`ifdef CONV2D_CLAMP_EN
    if (w_shifted < 0)         w_norm = '0;
    else if (w_shifted > MAXV) w_norm = '1;
    else                       w_norm = w_shifted[DW-1:0];
`else
    w_norm = DW'(w_shifted);
`endif
    w_last_tap = (r_kr == RW'(K - 1)) && (r_kc == RW'(K - 1));
    w_kc_n     = (r_kc == RW'(K - 1)) ? '0 : r_kc + 1'b1;
    w_kr_n     = (r_kc == RW'(K - 1)) ? r_kr + 1'b1 : r_kr;
    w_ncol     = (r_ocol == OW'(NO - 1)) ? '0 : r_ocol + 1'b1;
    w_nrow     = (r_ocol == OW'(NO - 1)) ? r_orow + 1'b1 : r_orow;
    w_last_pix = (r_ocol == OW'(NO - 1)) && (r_orow == OW'(NO - 1));
  end

  // dst_data is registered on the last DRAIN edge, so it is taken from w_acc_next which already holds the final tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      src_en   <= 1'b0;
      src_addr <= '0;
      dst_we   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
      r_shift  <= '0;
      r_orow   <= '0;
      r_ocol   <= '0;
      r_kr     <= '0;
      r_kc     <= '0;
      r_tap    <= '0;
      r_dcnt   <= '0;
      r_acc    <= '0;
      for (int unsigned i = 0; i < KK; i++) r_coef[i] <= CW'(1);
    end else begin
      r_acc  <= w_acc_next;
      dst_we <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (coef_we && (32'(coef_idx) < KK)) r_coef[coef_idx[TW-1:0]] <= coef_data;
          if (start) begin
            r_shift  <= norm_shift;
            r_orow   <= '0;
            r_ocol   <= '0;
            r_kr     <= '0;
            r_kc     <= '0;
            r_tap    <= '0;
            r_acc    <= '0;
            busy     <= 1'b1;
            src_en   <= 1'b1;
            src_addr <= '0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_last_tap) begin
            src_en  <= 1'b0;
            r_dcnt  <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_kr     <= w_kr_n;
            r_kc     <= w_kc_n;
            r_tap    <= r_tap + 1'b1;
            src_addr <= f_src(r_orow, r_ocol, w_kr_n, w_kc_n);
          end
        end
        S_DRAIN: begin
          if (r_dcnt == 2'(RD_LAT - 1)) begin
            dst_we   <= 1'b1;
            dst_addr <= DAW'(32'(r_orow) * NO + 32'(r_ocol));
            dst_data <= w_norm;
            r_state  <= S_WRITE;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_orow <= w_nrow;
          r_ocol <= w_ncol;
          if (w_last_pix) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_kr     <= '0;
            r_kc     <= '0;
            r_tap    <= '0;
            r_acc    <= '0;
            src_en   <= 1'b1;
            src_addr <= f_src(w_nrow, w_ncol, '0, '0);
            r_state  <= S_FETCH;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv2d_engine.md
# conv2d_engine

Parametrised 2-D convolution engine: a second-generation image filter for the processing toolkit. Reads an N×N unsigned image from a source BRAM port, convolves it with a runtime-programmable K×K signed kernel, normalises by a programmable right shift, and writes the (N-K+1)² valid-region result to a destination BRAM port in row-major order. Controlled by a start/busy/done handshake, not a free-running sequence.

## Interface
Parameters:
- N, 20, image width = height (pixels); N ≥ K
- K, 3, kernel size (K×K taps), 1..7
- DW, 8, pixel width (unsigned)
- CW, 4, coefficient width (signed two's complement)
- RD_LAT, 1, source BRAM read latency (cycles), 1..3
- SAW, 15, source address width; DAW, 14, destination address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to process the whole image
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write
- coef_we  in  1  kernel coefficient write strobe
- coef_idx  in  6  tap index, row-major (r*K+c), < K*K
- coef_data  in  CW  signed coefficient
- norm_shift  in  4  arithmetic right shift applied to the sum; sampled at start
- src_en  out  1  source read enable
- src_addr  out  SAW  source read address
- src_data  in  DW  source read data, valid RD_LAT cycles after src_en
- dst_we  out  1  destination write enable
- dst_addr  out  DAW  destination write address
- dst_data  out  DW  destination write data

## Operation
- Reset: every output 0 (busy, done, src_en, src_addr, dst_we, dst_addr, dst_data); FSM → IDLE; all coefficients = +1 (box kernel); counters 0.
- coef_we in IDLE writes coef[coef_idx] ← coef_data; ignored while busy or when coef_idx ≥ K*K.
- FSM: IDLE → (start) FETCH → DRAIN → WRITE → FETCH (next pixel) or DONE → IDLE.
- IDLE: start latches norm_shift, clears output row/col counters (orow, ocol), busy ← 1.
- FETCH: K*K cycles; tap (r,c) in row-major order; src_en=1, src_addr = (orow+r)*N + (ocol+c).
- DRAIN: RD_LAT cycles; src_en=0; the accumulator keeps absorbing returning data.
- Accumulate: acc += coef[tap] × {1'b0, src_data}; acc signed, width DW+1+CW+⌈log2(K*K)⌉, no overflow possible; cleared at entry to FETCH.
- WRITE: one cycle; dst_we=1, dst_addr = orow*(N-K+1)+ocol, dst_data = norm(acc >>> norm_shift); advance ocol, wrapping to 0 and incrementing orow at ocol = N-K.
- After writing pixel (N-K, N-K): DONE for one cycle (done=1, busy=0), then IDLE.
- start while busy: ignored. start coincident with coef_we in IDLE: the coefficient write takes effect and the run uses the new value.
- rst mid-run: immediate abort; no further writes; coefficients return to +1.

## Timing
- Per output pixel: K*K + RD_LAT + 1 cycles; total run = (N-K+1)²·(K*K+RD_LAT+1) cycles from the first FETCH cycle to the last WRITE cycle; done one cycle later.
- First src_en cycle = the cycle after start is sampled.
- dst_we is high for exactly one cycle per output pixel; dst_addr is strictly increasing 0..(N-K+1)²-1.
- done and dst_we are never high in the same cycle; busy=0 while done=1.

## Configuration
- CONV2D_CLAMP_EN defined: the shifted result saturates to [0, 2^DW-1] (negative → 0, overflow → 2^DW-1).
- Undefined: dst_data = low DW bits of the shifted result (wrap-around). Nothing else changes.

## Test plan
- N=20,K=3,RD_LAT=1, constant image 10, reset kernel, shift 0 → 324 writes, all dst_data=90, done exactly 3564 cycles after the first FETCH cycle.
- Constant image 255, box kernel, shift 0 → sum 2295; dst_data=255 with CONV2D_CLAMP_EN, 247 without; shift 4 → 143 both builds.
- Kernel centre = -8, others 0, image 50 → sum -400; dst_data=0 with clamp, 112 without.
- Ramp image pix=(row*N+col) mod 256, kernel tap(0,2)=1 only → dst pixel (0,17) = src(0,19)=19; checker verifies src_addr sequence and dst_addr ordering incl. row wrap at ocol=17.
- start pulsed mid-run and coef_we while busy → no restart, coefficients unchanged, output identical to clean run.
- rst asserted after 100 writes → outputs 0 same cycle (async), no further dst_we; new start produces a full correct run with the box kernel.
